// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK polarity and the
// synchronised bus-strobe bundle produced by i2c_bus_sync.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_BYTE   = 3'd3,
    WR_ACK    = 3'd4,
    RD_BYTE   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef struct packed {
    logic scl;
    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
  } i2c_bus_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronisers for scl/sda plus edge, START and STOP strobes.
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     scl,
  input  logic     sda,
  output i2c_bus_t bus
);

  // [1:0] is the synchroniser, [2] the previous synchronised value
  logic [2:0] scl_sr, sda_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sr <= '1;
      sda_sr <= '1;
    end else begin
      scl_sr <= {scl_sr[1:0], scl};
      sda_sr <= {sda_sr[1:0], sda};
    end
  end

  always_comb begin
    bus          = '0;
    bus.scl      = scl_sr[1];
    bus.sda      = sda_sr[1];
    bus.scl_rise =  scl_sr[1] & ~scl_sr[2];
    bus.scl_fall = ~scl_sr[1] &  scl_sr[2];
    bus.start    = ~sda_sr[1] &  sda_sr[2] & scl_sr[1];
    bus.stop     =  sda_sr[1] & ~sda_sr[2] & scl_sr[1];
  end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target: 7-bit addressing, byte writes to rx_data, byte reads from
// tx_data. Never stretches SCL; only pulls SDA low or releases it.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       addr_match
);

  i2c_bus_t   bus;
  i2c_state_e state;
  logic [2:0] cnt;
  logic [7:0] shreg;
  logic       sda_oe;
  logic       rw;
  logic       ack_ok;
  logic [7:0] byte_in;

  i2c_bus_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .scl   (scl),
    .sda   (sda),
    .bus   (bus)
  );

  // Async reset of sda_oe releases the line without waiting for a clock
  assign sda     = sda_oe ? 1'b0 : 1'bz;
  assign byte_in = {shreg[6:0], bus.sda};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      sda_oe     <= 1'b0;
      rw         <= 1'b0;
      ack_ok     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_load    <= 1'b0;
      busy       <= 1'b0;
      addr_match <= 1'b0;
    end else begin
      tx_load    <= 1'b0;
      rx_valid   <= 1'b0;
      addr_match <= 1'b0;
      if (bus.start) begin
        state  <= ADDR;
        cnt    <= '0;
        sda_oe <= 1'b0;
      end else if (bus.stop) begin
        state  <= IDLE;
        cnt    <= '0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ADDR: if (bus.scl_rise) begin
            shreg <= byte_in;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                addr_match <= 1'b1;
                busy       <= 1'b1;
                rw         <= byte_in[0];
                state      <= ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end
            end
          end
          // First fall (end of bit 8) asserts ACK, second fall ends the ACK bit
          ADDR_ACK: if (bus.scl_fall) begin
            cnt <= '0;
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else if (rw) begin
              tx_load <= 1'b1;
              shreg   <= tx_data;
              sda_oe  <= ~tx_data[7];
              state   <= RD_BYTE;
            end else begin
              sda_oe <= 1'b0;
              state  <= WR_BYTE;
            end
          end
          WR_BYTE: if (bus.scl_rise) begin
            shreg <= byte_in;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              rx_data  <= byte_in;
              rx_valid <= 1'b1;
              state    <= WR_ACK;
            end
          end
          WR_ACK: if (bus.scl_fall) begin
            cnt <= '0;
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              state  <= WR_BYTE;
            end
          end
          RD_BYTE: if (bus.scl_fall) begin
            if (cnt == 3'd7) begin
              cnt    <= '0;
              sda_oe <= 1'b0;
              ack_ok <= 1'b0;
              state  <= RD_ACK;
            end else begin
              shreg  <= {shreg[6:0], 1'b0};
              sda_oe <= ~shreg[6];
              cnt    <= cnt + 3'd1;
            end
          end
          // Reload on the ACK rise; the MSB goes out on the following fall
          RD_ACK: begin
            if (bus.scl_rise) begin
              if (bus.sda == I2C_ACK) begin
                tx_load <= 1'b1;
                shreg   <= tx_data;
                ack_ok  <= 1'b1;
              end else begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end
            end else if (bus.scl_fall && ack_ok) begin
              sda_oe <= ~shreg[7];
              cnt    <= '0;
              state  <= RD_BYTE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bit-banged I2C master driving i2c_slave_ctrl; DUT output pulses are checked
// against an expected-event queue by an independent monitor.
module tb_i2c_slave_ctrl;

  localparam int Q = 50;
  localparam int H = 100;

  typedef enum logic [1:0] {EV_AM, EV_TXL, EV_RXV} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_oe = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load, rx_valid, busy, addr_match;
  logic [7:0] rx_data;
  wire        sda_bus;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  assign sda_bus = m_oe ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h50)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl        (scl),
    .sda        (sda_bus),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .addr_match (addr_match)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_e k, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input ev_kind_e k, input logic [7:0] v);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse: got kind %0d value %0h expected none", k, v);
    end else begin
      e = exp_q.pop_front();
      chk("pulse_kind", 32'(k), 32'(e.kind));
      chk("pulse_value", 32'(v), 32'(e.val));
    end
  endtask

  always @(negedge clk) begin
    if (addr_match) pop_chk(EV_AM, 8'h00);
    if (tx_load)    pop_chk(EV_TXL, 8'h00);
    if (rx_valid)   pop_chk(EV_RXV, rx_data);
  end

  // Bus primitives: every task ends with scl low, except stop_c
  task automatic start_c();
    m_oe = 1'b0; #Q; scl = 1'b1; #H; m_oe = 1'b1; #H; scl = 1'b0;
  endtask

  task automatic stop_c();
    #Q; m_oe = 1'b1; #Q; scl = 1'b1; #H; m_oe = 1'b0; #H;
  endtask

  task automatic write_bit(input logic b);
    #Q; m_oe = ~b; #Q; scl = 1'b1; #H; scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    #Q; m_oe = 1'b0; #Q; scl = 1'b1; #Q; b = sda_bus; #Q; scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    #23;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_load", tx_load, 1'b0);
    chk("rst_addr_match", addr_match, 1'b0);
    chk("rst_sda", sda_bus, 1'b1);
    #20 rst_n = 1'b1;
    #100;

    // S1: write A5 to 0x50
    push(EV_AM, 8'h00);
    push(EV_RXV, 8'hA5);
    start_c();
    send_byte(8'hA0, ack); chk("s1_addr_ack", ack, 1'b0);
    chk("s1_busy", busy, 1'b1);
    send_byte(8'hA5, ack); chk("s1_data_ack", ack, 1'b0);
    stop_c();
    #50;
    chk("s1_busy_after_stop", busy, 1'b0);
    chk("s1_rx_data", rx_data, 8'hA5);

    // S2: read 3C, master NACK
    tx_data = 8'h3C;
    push(EV_AM, 8'h00);
    push(EV_TXL, 8'h00);
    start_c();
    send_byte(8'hA1, ack); chk("s2_addr_ack", ack, 1'b0);
    recv_byte(d, 1'b1);    chk("s2_read_byte", d, 8'h3C);
    #50;
    chk("s2_busy_after_nack", busy, 1'b0);
    read_bit(ack); chk("s2_wait_stop_released", ack, 1'b1);
    stop_c();

    // S3: wrong address 0x51 is not acknowledged
    start_c();
    send_byte(8'hA2, ack); chk("s3_no_ack", ack, 1'b1);
    chk("s3_busy", busy, 1'b0);
    stop_c();

    // S4: write 11, repeated START, two reads of 22 (ACK then NACK)
    tx_data = 8'h22;
    push(EV_AM, 8'h00);
    push(EV_RXV, 8'h11);
    push(EV_AM, 8'h00);
    push(EV_TXL, 8'h00);
    push(EV_TXL, 8'h00);
    start_c();
    send_byte(8'hA0, ack); chk("s4_addr_ack", ack, 1'b0);
    send_byte(8'h11, ack); chk("s4_data_ack", ack, 1'b0);
    start_c();
    send_byte(8'hA1, ack); chk("s4_raddr_ack", ack, 1'b0);
    recv_byte(d, 1'b0);    chk("s4_read0", d, 8'h22);
    recv_byte(d, 1'b1);    chk("s4_read1", d, 8'h22);
    stop_c();
    chk("s4_rx_data", rx_data, 8'h11);

    // S6: STOP after 4 data bits, then a normal write
    push(EV_AM, 8'h00);
    start_c();
    send_byte(8'hA0, ack); chk("s6_addr_ack", ack, 1'b0);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    stop_c();
    #50;
    chk("s6_busy_after_stop", busy, 1'b0);
    chk("s6_rx_data_kept", rx_data, 8'h11);
    push(EV_AM, 8'h00);
    push(EV_RXV, 8'h5A);
    start_c();
    send_byte(8'hA0, ack); chk("s6_next_addr_ack", ack, 1'b0);
    send_byte(8'h5A, ack); chk("s6_next_data_ack", ack, 1'b0);
    stop_c();

    // S5: reset while the target drives a 0 data bit
    tx_data = 8'h3C;
    push(EV_AM, 8'h00);
    push(EV_TXL, 8'h00);
    start_c();
    send_byte(8'hA1, ack); chk("s5_addr_ack", ack, 1'b0);
    #Q;
    chk("s5_driving_low", sda_bus, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("s5_sda_released", sda_bus, 1'b1);
    chk("s5_busy", busy, 1'b0);
    chk("s5_rx_data", rx_data, 8'h00);
    chk("s5_tx_load", tx_load, 1'b0);
    chk("s5_rx_valid", rx_valid, 1'b0);
    chk("s5_addr_match", addr_match, 1'b0);
    #20 rst_n = 1'b1;
    recv_byte(d, 1'b1); chk("s5_ignored_bus", d, 8'hFF);
    stop_c();
    push(EV_AM, 8'h00);
    push(EV_RXV, 8'hC3);
    start_c();
    send_byte(8'hA0, ack); chk("s5_recover_addr_ack", ack, 1'b0);
    send_byte(8'hC3, ack); chk("s5_recover_data_ack", ack, 1'b0);
    stop_c();

    #200;
    chk("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
